// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_pkg
// Description : Shared types and constants for the SPI-to-I2C bridge
//               controller: FSM state encodings, header bit positions,
//               error cause codes and the LEN-field range check.
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

  // Header byte0 layout: {rw, addr[6:0]}
  localparam int RW_BIT   = 7;
  localparam int ADDR_MSB = 6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR_LEN   = 3'd1,
    ST_WR_FILL   = 3'd2,
    ST_I2C_GO    = 3'd3,
    ST_I2C_XFER  = 3'd4,
    ST_NACK_WAIT = 3'd5,
    ST_RD_DRAIN  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_BAD_LEN  = 3'd1,
    ERR_UNDERRUN = 3'd2,
    ERR_OVERFLOW = 3'd3,
    ERR_NACK     = 3'd4,
    ERR_TIMEOUT  = 3'd5
  } err_cause_e;

  // A burst length is legal when it is non-zero and fits in one FIFO.
  function automatic logic len_valid(input logic [7:0] len, input int depth);
    return (len != 8'd0) && (int'(len) <= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bridge_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bridge_fifo
// Description : Synchronous show-ahead FIFO with registered full/empty flags,
//               occupancy count and a synchronous flush. Head reads as zero
//               while empty. DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int                c_aw       = $clog2(DEPTH);
  localparam logic [c_aw-1:0]   c_ptr_one  = c_aw'(1);
  localparam logic [c_aw:0]     c_cnt_one  = (c_aw + 1)'(1);
  localparam logic [c_aw:0]     c_full_cnt = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q, rd_ptr_q;
  logic [c_aw:0]    count_q, w_count_d;
  logic             full_q, empty_q;
  logic             w_do_push, w_do_pop;

  // Pushes into a full FIFO and pops from an empty one are dropped.
  assign w_do_push = i_push & ~full_q;
  assign w_do_pop  = i_pop  & ~empty_q;

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_d = count_q;
    if (w_do_push && !w_do_pop) begin
      w_count_d = count_q + c_cnt_one;
    end else if (w_do_pop && !w_do_push) begin
      w_count_d = count_q - c_cnt_one;
    end
  end

  // Storage array; no reset needed since reads are gated by empty.
  always_ff @(posedge i_Clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  // Pointers, count and registered flags; flush wins over push/pop.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + c_ptr_one;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + c_ptr_one;
      count_q <= w_count_d;
      full_q  <= (w_count_d == c_full_cnt);
      empty_q <= (w_count_d == '0);
    end
  end

  assign o_rdata = empty_q ? '0 : mem_q[rd_ptr_q];
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/spi_i2c_bridge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_i2c_bridge_ctrl
// Description : Bridges SPI slave byte frames {rw,addr}, LEN, data... onto an
//               I2C master byte interface with buffered read/write bursts,
//               NACK and timeout error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_i2c_bridge_ctrl
  import bridge_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic                          i_SPI_RX_DV,
  input  logic [7:0]                    i_SPI_RX_Byte,
  output logic                          o_SPI_TX_DV,
  output logic [7:0]                    o_SPI_TX_Byte,
  output logic                          o_I2C_Start,
  output logic [6:0]                    o_I2C_Addr,
  output logic                          o_I2C_Rw,
  output logic [$clog2(FIFO_DEPTH):0]   o_I2C_Len,
  input  logic                          i_I2C_Byte_Req,
  output logic [7:0]                    o_I2C_Wr_Byte,
  input  logic                          i_I2C_Rd_DV,
  input  logic [7:0]                    i_I2C_Rd_Byte,
  input  logic                          i_I2C_Done,
  input  logic                          i_I2C_Nack,
  output logic                          o_Busy,
  output logic                          o_Err
);

  localparam int                  c_len_w    = $clog2(FIFO_DEPTH) + 1;
  localparam int                  c_tmo_w    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_len_w-1:0]  c_len_one  = c_len_w'(1);
  localparam logic [c_tmo_w-1:0]  c_tmo_one  = c_tmo_w'(1);
  localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

  state_e               state_q;
  logic [6:0]           addr_q;
  logic                 rw_q;
  logic [c_len_w-1:0]   len_q, cnt_q;
  logic [c_tmo_w-1:0]   tmo_q;
  logic                 busy_q, err_q, start_q, spi_tx_dv_q, pend_q;
  logic [7:0]           spi_tx_byte_q;

  logic                 w_in_xfer, w_wait_i2c, w_i2c_evt, w_timeout;
  logic                 w_tx_push, w_tx_pop, w_tx_flush, w_tx_empty, w_tx_full;
  logic                 w_rx_push, w_rx_pop, w_rx_flush, w_rx_empty, w_rx_full;
  logic [7:0]           w_rx_head;
  logic [c_len_w-1:0]   w_tx_cnt, w_rx_cnt;
  logic                 w_unused;

  assign w_in_xfer  = (state_q == ST_I2C_XFER);
  assign w_wait_i2c = w_in_xfer || (state_q == ST_NACK_WAIT);
  assign w_i2c_evt  = i_I2C_Byte_Req | i_I2C_Rd_DV | i_I2C_Done;
  assign w_timeout  = w_wait_i2c && !w_i2c_evt && (tmo_q == c_tmo_last);

  // Accepting a new header also clears any leftovers from an aborted burst.
  assign w_tx_push  = (state_q == ST_WR_FILL) && i_SPI_RX_DV;
  assign w_tx_pop   = w_in_xfer && !rw_q && i_I2C_Byte_Req;
  assign w_tx_flush = (w_in_xfer && i_I2C_Nack) || w_timeout ||
                      ((state_q == ST_IDLE) && i_SPI_RX_DV);
  assign w_rx_push  = w_in_xfer && rw_q && i_I2C_Rd_DV;
  assign w_rx_pop   = (state_q == ST_RD_DRAIN) && !w_rx_empty &&
                      (pend_q || i_SPI_RX_DV);
  assign w_rx_flush = w_timeout || ((state_q == ST_IDLE) && i_SPI_RX_DV);

  bridge_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_flush (w_tx_flush),
    .i_push  (w_tx_push),
    .i_wdata (i_SPI_RX_Byte),
    .i_pop   (w_tx_pop),
    .o_rdata (o_I2C_Wr_Byte),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_cnt)
  );

  bridge_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_flush (w_rx_flush),
    .i_push  (w_rx_push),
    .i_wdata (i_I2C_Rd_Byte),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_cnt)
  );

  // Occupancy counts and TX full are not needed by the control path.
  assign w_unused = ^{w_tx_cnt, w_rx_cnt, w_tx_full};

  // Frame sequencer: header decode, burst fill, I2C handshake and read drain.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      rw_q          <= 1'b0;
      len_q         <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      start_q       <= 1'b0;
      spi_tx_dv_q   <= 1'b0;
      spi_tx_byte_q <= '0;
      pend_q        <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      spi_tx_dv_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_SPI_RX_DV) begin
            addr_q  <= i_SPI_RX_Byte[ADDR_MSB:0];
            rw_q    <= i_SPI_RX_Byte[RW_BIT];
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_HDR_LEN;
          end
        end
        ST_HDR_LEN: begin
          if (i_SPI_RX_DV) begin
            if (!len_valid(i_SPI_RX_Byte, FIFO_DEPTH)) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              len_q   <= c_len_w'(i_SPI_RX_Byte);
              cnt_q   <= '0;
              state_q <= rw_q ? ST_I2C_GO : ST_WR_FILL;
            end
          end
        end
        ST_WR_FILL: begin
          if (i_SPI_RX_DV) begin
            cnt_q <= cnt_q + c_len_one;
            if ((cnt_q + c_len_one) == len_q) state_q <= ST_I2C_GO;
          end
        end
        ST_I2C_GO: begin
          start_q <= 1'b1;
          tmo_q   <= '0;
          state_q <= ST_I2C_XFER;
        end
        ST_I2C_XFER, ST_NACK_WAIT: begin
          if (w_timeout) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= w_i2c_evt ? '0 : (tmo_q + c_tmo_one);
            if (state_q == ST_NACK_WAIT) begin
              if (i_I2C_Done) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              if (!rw_q && i_I2C_Byte_Req && w_tx_empty) err_q <= 1'b1;
              if (rw_q && i_I2C_Rd_DV && w_rx_full)      err_q <= 1'b1;
              if (i_I2C_Nack) begin
                err_q <= 1'b1;
                if (i_I2C_Done) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                end else begin
                  state_q <= ST_NACK_WAIT;
                end
              end else if (i_I2C_Done) begin
                if (rw_q) begin
                  pend_q  <= 1'b1;
                  state_q <= ST_RD_DRAIN;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                end
              end
            end
          end
        end
        ST_RD_DRAIN: begin
          // The first byte is preloaded on entry; each dummy SPI byte then
          // fetches the next. A dummy arriving with nothing left has shifted
          // out the final byte, so the frame is complete.
          if (pend_q || i_SPI_RX_DV) begin
            pend_q <= 1'b0;
            if (!w_rx_empty) begin
              spi_tx_byte_q <= w_rx_head;
              spi_tx_dv_q   <= 1'b1;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_SPI_TX_DV   = spi_tx_dv_q;
  assign o_SPI_TX_Byte = spi_tx_byte_q;
  assign o_I2C_Start   = start_q;
  assign o_I2C_Addr    = addr_q;
  assign o_I2C_Rw      = rw_q;
  assign o_I2C_Len     = len_q;
  assign o_Busy        = busy_q;
  assign o_Err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_i2c_bridge_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_i2c_bridge_ctrl
// Description : Directed self-checking bench for spi_i2c_bridge_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_i2c_bridge_ctrl;

  localparam int DEPTH = 16;
  localparam int TMO   = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_rx_dv = 1'b0;
  logic [7:0] spi_rx_byte = 8'h00;
  logic       spi_tx_dv;
  logic [7:0] spi_tx_byte;
  logic       i2c_start;
  logic [6:0] i2c_addr;
  logic       i2c_rw;
  logic [4:0] i2c_len;
  logic       i2c_byte_req = 1'b0;
  logic [7:0] i2c_wr_byte;
  logic       i2c_rd_dv = 1'b0;
  logic [7:0] i2c_rd_byte = 8'h00;
  logic       i2c_done = 1'b0;
  logic       i2c_nack = 1'b0;
  logic       busy;
  logic       err;

  int         n_checks = 0;
  int         n_errors = 0;
  int         start_cnt = 0;
  int         base_starts;
  int         seen;
  int         cyc;
  logic [7:0] tx_q[$];

  spi_i2c_bridge_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_SPI_RX_DV    (spi_rx_dv),
    .i_SPI_RX_Byte  (spi_rx_byte),
    .o_SPI_TX_DV    (spi_tx_dv),
    .o_SPI_TX_Byte  (spi_tx_byte),
    .o_I2C_Start    (i2c_start),
    .o_I2C_Addr     (i2c_addr),
    .o_I2C_Rw       (i2c_rw),
    .o_I2C_Len      (i2c_len),
    .i_I2C_Byte_Req (i2c_byte_req),
    .o_I2C_Wr_Byte  (i2c_wr_byte),
    .i_I2C_Rd_DV    (i2c_rd_dv),
    .i_I2C_Rd_Byte  (i2c_rd_byte),
    .i_I2C_Done     (i2c_done),
    .i_I2C_Nack     (i2c_nack),
    .o_Busy         (busy),
    .o_Err          (err)
  );

  always #5 clk = ~clk;

  // Count Start pulses and capture bytes handed to the SPI slave.
  always @(negedge clk) begin
    if (i2c_start) start_cnt++;
    if (spi_tx_dv) tx_q.push_back(spi_tx_byte);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All driver tasks start and end on a falling edge.
  task automatic spi_byte(input logic [7:0] b);
    spi_rx_dv = 1'b1; spi_rx_byte = b;
    @(negedge clk);
    spi_rx_dv = 1'b0;
  endtask

  task automatic byte_req(input string tag, input logic [7:0] exp);
    check(tag, i2c_wr_byte, exp);
    i2c_byte_req = 1'b1;
    @(negedge clk);
    i2c_byte_req = 1'b0;
  endtask

  task automatic rd_byte(input logic [7:0] b);
    i2c_rd_dv = 1'b1; i2c_rd_byte = b;
    @(negedge clk);
    i2c_rd_dv = 1'b0;
  endtask

  task automatic pulse_done();
    i2c_done = 1'b1;
    @(negedge clk);
    i2c_done = 1'b0;
  endtask

  task automatic pulse_nack();
    i2c_nack = 1'b1;
    @(negedge clk);
    i2c_nack = 1'b0;
  endtask

  task automatic wait_start(output int found);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i2c_start) begin
        found = 1;
        break;
      end
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_start", i2c_start, 0);
    check("rst_addr", i2c_addr, 0);
    check("rst_len", i2c_len, 0);
    check("rst_wr_byte", i2c_wr_byte, 0);
    check("rst_tx_dv", spi_tx_dv, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- write burst ----------------
    base_starts = start_cnt;
    spi_byte(8'h2A);
    check("wr_busy_hdr", busy, 1);
    spi_byte(8'h03);
    spi_byte(8'h11);
    spi_byte(8'h22);
    spi_byte(8'h33);
    wait_start(seen);
    check("wr_start_seen", seen, 1);
    check("wr_addr", i2c_addr, 8'h2A);
    check("wr_rw", i2c_rw, 0);
    check("wr_len", i2c_len, 3);
    byte_req("wr_byte0", 8'h11);
    byte_req("wr_byte1", 8'h22);
    byte_req("wr_byte2", 8'h33);
    pulse_done();
    check("wr_busy_end", busy, 0);
    check("wr_err", err, 0);
    check("wr_start_cnt", start_cnt - base_starts, 1);

    // ---------------- read burst ----------------
    tx_q.delete();
    base_starts = start_cnt;
    spi_byte(8'hAA);
    spi_byte(8'h02);
    wait_start(seen);
    check("rd_start_seen", seen, 1);
    check("rd_addr", i2c_addr, 8'h2A);
    check("rd_rw", i2c_rw, 1);
    check("rd_len", i2c_len, 2);
    rd_byte(8'h5C);
    rd_byte(8'h7E);
    pulse_done();
    repeat (3) @(negedge clk);
    check("rd_busy_drain", busy, 1);
    spi_byte(8'h00);
    repeat (2) @(negedge clk);
    spi_byte(8'h00);
    repeat (3) @(negedge clk);
    check("rd_tx_count", tx_q.size(), 2);
    check("rd_tx0", tx_q[0], 8'h5C);
    check("rd_tx1", tx_q[1], 8'h7E);
    check("rd_busy_end", busy, 0);
    check("rd_err", err, 0);
    check("rd_start_cnt", start_cnt - base_starts, 1);

    // ---------------- bad length ----------------
    base_starts = start_cnt;
    spi_byte(8'h2A);
    spi_byte(8'h00);
    check("len0_err", err, 1);
    check("len0_busy", busy, 0);
    spi_byte(8'h2A);
    check("len17_err_cleared", err, 0);
    spi_byte(8'(DEPTH + 1));
    check("len17_err", err, 1);
    check("len17_busy", busy, 0);
    repeat (4) @(negedge clk);
    check("badlen_no_start", start_cnt - base_starts, 0);

    // ---------------- maximum length burst ----------------
    spi_byte(8'h33);
    spi_byte(8'(DEPTH));
    check("max_err", err, 0);
    for (int i = 0; i < DEPTH; i++) spi_byte(8'(8'hC0 + i));
    wait_start(seen);
    check("max_start_seen", seen, 1);
    check("max_len", i2c_len, DEPTH);
    for (int i = 0; i < DEPTH; i++) byte_req("max_byte", 8'(8'hC0 + i));
    check("max_fifo_empty", i2c_wr_byte, 0);
    pulse_done();
    check("max_busy_end", busy, 0);
    check("max_err_end", err, 0);

    // ---------------- NACK ----------------
    spi_byte(8'h2A);
    spi_byte(8'h02);
    spi_byte(8'hA1);
    spi_byte(8'hB2);
    wait_start(seen);
    check("nack_start_seen", seen, 1);
    byte_req("nack_byte0", 8'hA1);
    pulse_nack();
    check("nack_err", err, 1);
    check("nack_tx_flushed", i2c_wr_byte, 0);
    check("nack_busy_wait", busy, 1);
    pulse_done();
    check("nack_busy_end", busy, 0);
    check("nack_err_hold", err, 1);
    spi_byte(8'h10);
    check("nack_hdr_clears_err", err, 0);
    check("nack_hdr_addr", i2c_addr, 8'h10);
    spi_byte(8'h00);

    // ---------------- timeout ----------------
    spi_byte(8'hAA);
    spi_byte(8'h01);
    wait_start(seen);
    check("tmo_start_seen", seen, 1);
    cyc = 0;
    for (int i = 0; i < 2 * TMO; i++) begin
      @(negedge clk);
      cyc++;
      if (err) break;
    end
    check("tmo_cycles", cyc, TMO);
    check("tmo_err", err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_tx_empty", i2c_wr_byte, 0);

    // ---------------- reset mid-write ----------------
    spi_byte(8'h2A);
    spi_byte(8'h04);
    spi_byte(8'h01);
    spi_byte(8'h02);
    check("rstmid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_addr", i2c_addr, 0);
    check("rstmid_len", i2c_len, 0);
    check("rstmid_wr_byte", i2c_wr_byte, 0);
    check("rstmid_start", i2c_start, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base_starts = start_cnt;
    repeat (30) @(negedge clk);
    check("rstmid_no_start", start_cnt - base_starts, 0);
    check("rstmid_idle", busy, 0);

    // A fresh frame still works after the abort.
    spi_byte(8'h05);
    spi_byte(8'h01);
    spi_byte(8'h77);
    wait_start(seen);
    check("post_start_seen", seen, 1);
    check("post_addr", i2c_addr, 8'h05);
    byte_req("post_byte", 8'h77);
    pulse_done();
    check("post_busy", busy, 0);
    check("post_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
